// File: rtl/uart_tx_sequencer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_sequencer_if
// Bundles the processor-side register strobes, the UART core handshake and
// the status lines of the transmit sequencer into one connection.
//
// Ports (signals):
//   wr_i, wdata_i      processor write strobe and byte to buffer
//   start_i            control-register send bit (level)
//   ready_i            UART core "character finished" pulse
//   err_clr_i          clears the sticky error flags
//   tx_data_o, send_o  byte and start pulse towards the UART core
//   we_o               pulse that writes 0 into the control register
//   busy_o             sequencer not idle
//   full_o, empty_o,
//   count_o            FIFO status and occupancy
//   overflow_o,
//   timeout_o          sticky error flags
//
// Modports:
//   master  processor / UART-core side (drives the *_i signals)
//   slave   sequencer side (drives the *_o signals)
// -----------------------------------------------------------------------------
interface uart_tx_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
);
   logic                         wr_i;
   logic [DATA_W-1:0]            wdata_i;
   logic                         start_i;
   logic                         ready_i;
   logic                         err_clr_i;
   logic [DATA_W-1:0]            tx_data_o;
   logic                         send_o;
   logic                         we_o;
   logic                         busy_o;
   logic                         full_o;
   logic                         empty_o;
   logic [$clog2(DEPTH+1)-1:0]   count_o;
   logic                         overflow_o;
   logic                         timeout_o;

   modport master (
      output wr_i, wdata_i, start_i, ready_i, err_clr_i,
      input  tx_data_o, send_o, we_o, busy_o, full_o, empty_o, count_o,
             overflow_o, timeout_o
   );

   modport slave (
      input  wr_i, wdata_i, start_i, ready_i, err_clr_i,
      output tx_data_o, send_o, we_o, busy_o, full_o, empty_o, count_o,
             overflow_o, timeout_o
   );
endinterface

// File: rtl/uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// uart_tx_sequencer
// Buffers bytes written by the processor in a small circular FIFO and drains
// them one at a time into the UART transmitter core using a send/ready
// handshake. When a burst ends (or a start arrives with nothing buffered) it
// pulses we_o so the control register's send bit is cleared. Waiting for the
// core is supervised by a timeout; overflow and timeout are sticky flags.
//
// Parameters:
//   DATA_W       width of one character
//   DEPTH        FIFO entries, power of two, >= 2
//   TIMEOUT_CYC  max cycles waiting for ready_i after send_o (0 = no timeout)
//   AUTO_START   1: start a burst whenever the FIFO is non-empty
//
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous reset, active low
//   bus     uart_tx_sequencer_if.slave (all data/handshake/status signals)
// -----------------------------------------------------------------------------
module uart_tx_sequencer #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 20000,
   parameter int AUTO_START  = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   uart_tx_sequencer_if.slave   bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   // The timer only has to count up to TIMEOUT_CYC-1.
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : TMR_ZERO;
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   localparam bit TMO_EN  = (TIMEOUT_CYC != 0);
   localparam bit AUTO_EN = (AUTO_START != 0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SEND  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_CLEAR = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_s;

   logic [DATA_W-1:0]   mem_r [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    count_r;
   logic [DATA_W-1:0]   tx_data_r;
   logic [TMR_W-1:0]    timer_r;
   logic                overflow_r;
   logic                timeout_r;

   logic                full_s;
   logic                empty_s;
   logic                push_s;
   logic                pop_s;
   logic                timeout_evt_s;

   assign full_s  = (count_r == CNT_FULL);
   assign empty_s = (count_r == CNT_ZERO);

   // A write to a full FIFO is dropped; it only raises the overflow flag.
   assign push_s = bus.wr_i && !full_s;
   // Only LOAD consumes; the empty guard protects against a corrupted state.
   assign pop_s  = (state_r == ST_LOAD) && !empty_s;

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and timeout detection.
   always_comb begin
      state_s       = state_r;
      timeout_evt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if ((bus.start_i || AUTO_EN) && !empty_s) begin
               state_s = ST_LOAD;
            end else if (bus.start_i && empty_s) begin
               // Nothing to send: just acknowledge the control register.
               state_s = ST_CLEAR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_s = ST_SEND;
         end
         ST_SEND: begin
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            // ready_i is checked first so it wins on the last timer cycle.
            if (bus.ready_i) begin
               if (!empty_s) begin
                  state_s = ST_LOAD;
               end else begin
                  state_s = ST_CLEAR;
               end
            end else if (TMO_EN && (timer_r == TMR_LAST)) begin
               timeout_evt_s = 1'b1;
               state_s       = ST_CLEAR;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_CLEAR: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FIFO storage; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.wdata_i;
      end
   end

   // FIFO pointers and occupancy; a timeout flushes everything, including a
   // byte pushed in that same cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else if (timeout_evt_s) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Byte presented to the UART core; held until the next LOAD.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         tx_data_r <= DATA_ZERO;
      end else if (pop_s) begin
         tx_data_r <= mem_r[rd_ptr_r];
      end
   end

   // Response timer: cleared when a character is launched, counts while waiting.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         timer_r <= TMR_ZERO;
      end else if (state_r == ST_SEND) begin
         timer_r <= TMR_ZERO;
      end else if ((state_r == ST_WAIT) && !bus.ready_i && TMO_EN && (timer_r != TMR_LAST)) begin
         timer_r <= timer_r + TMR_ONE;
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         overflow_r <= 1'b0;
         timeout_r  <= 1'b0;
      end else begin
         if (bus.wr_i && full_s) begin
            overflow_r <= 1'b1;
         end else if (bus.err_clr_i) begin
            overflow_r <= 1'b0;
         end
         if (timeout_evt_s) begin
            timeout_r <= 1'b1;
         end else if (bus.err_clr_i) begin
            timeout_r <= 1'b0;
         end
      end
   end

   // Moore outputs decoded straight from registers, so they cannot glitch.
   assign bus.send_o     = (state_r == ST_SEND);
   assign bus.we_o       = (state_r == ST_CLEAR);
   assign bus.busy_o     = (state_r != ST_IDLE);
   assign bus.tx_data_o  = tx_data_r;
   assign bus.full_o     = full_s;
   assign bus.empty_o    = empty_s;
   assign bus.count_o    = count_r;
   assign bus.overflow_o = overflow_r;
   assign bus.timeout_o  = timeout_r;

endmodule
